// File: rtl/ddr4_vref_mr_seq.sv
// rtl/ddr4_vref_mr_seq.sv - post-training DDR4 VREFDQ MR6 programming sequencer
module ddr4_vref_mr_seq #(
   parameter int NUM_RANKS   = 1,
   parameter int TVREF_WAIT  = 64,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                     SCLK,
   input  logic                     reset_n,
   input  logic                     training_complete,
   input  logic                     skip_vref_training,
   input  logic                     rerun_vref,
   input  logic [NUM_RANKS-1:0]     rank_enable,
   input  logic [7*NUM_RANKS-1:0]   vref_mr6_values,
   input  logic                     cal_init_ack,
   output logic                     cal_init_mr_w_req,
   output logic [7:0]               cal_init_mr_addr,
   output logic [17:0]              cal_init_mr_wr_data,
   output logic [17:0]              cal_init_mr_wr_mask,
   output logic [NUM_RANKS-1:0]     cal_init_cs,
   output logic                     select,
   output logic                     ddr4_vref_complete,
   output logic                     vref_error
);

   localparam int WW = $clog2(TVREF_WAIT + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [WW-1:0] C_WAIT_LOAD = WW'(TVREF_WAIT);
   localparam logic [TW-1:0] C_TO_LAST   = TW'(ACK_TIMEOUT - 1);
   localparam logic [2:0]    C_RANK_END  = 3'(NUM_RANKS);
   localparam logic [7:0]    C_MR6_ADDR  = 8'h06;
   localparam logic [17:0]   C_MR6_MASK  = 18'h3FF00;

   typedef enum logic [3:0] {
      S_IDLE, S_RANK_SEL, S_ENTER, S_ENTER_WAIT, S_WRITE,
      S_WRITE_WAIT, S_EXIT, S_EXIT_WAIT, S_DONE, S_ERROR
   } state_t;

   state_t                r_state, w_state_next;
   logic [2:0]            r_rank, w_rank_next;
   logic [6:0]            r_val_q, w_val_next;
   logic [WW-1:0]         r_wait, w_wait_next;
   logic [TW-1:0]         r_to, w_to_next;

   logic                  r_req;
   logic [7:0]            r_addr;
   logic [17:0]           r_data;
   logic [17:0]           r_mask;
   logic [NUM_RANKS-1:0]  r_cs;
   logic                  r_select;
   logic                  r_complete;
   logic                  r_error;

   logic                  w_is_req;
   logic                  w_ack;
   logic                  w_timeout;
   logic                  w_req_next;
   logic                  w_sel_next;
   logic                  w_rank_en;
   logic [6:0]            w_rank_val;
   logic [NUM_RANKS-1:0]  w_cs_onehot;
   logic                  w_vref_enable_bit;

   // Decode the current rank index into its enable, VREF slice and one-hot chip select
   always_comb begin
      w_rank_en   = 1'b0;
      w_rank_val  = '0;
      w_cs_onehot = '0;
      for (int i = 0; i < NUM_RANKS; i++) begin
         if (r_rank == 3'(i)) begin
            w_rank_en      = rank_enable[i];
            w_rank_val     = vref_mr6_values[7*i +: 7];
            w_cs_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state logic plus rank, latched value, wait and ack-timeout counters
   always_comb begin
      w_state_next = r_state;
      w_rank_next  = r_rank;
      w_val_next   = r_val_q;
      w_wait_next  = r_wait;
      w_is_req     = (r_state == S_ENTER) || (r_state == S_WRITE) || (r_state == S_EXIT);
      // an ack only counts against a request the arbiter can actually see
      w_ack        = cal_init_ack & r_req & w_is_req;
      w_timeout    = w_is_req & ~w_ack & (r_to == C_TO_LAST);

      case (r_state)
         S_IDLE: begin
            if (training_complete) begin
               if (skip_vref_training) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_RANK_SEL;
                  w_rank_next  = 3'd0;
               end
            end
         end
         S_RANK_SEL: begin
            if (r_rank >= C_RANK_END) begin
               w_state_next = S_DONE;
            end else if (w_rank_en) begin
               w_val_next   = w_rank_val;
               w_state_next = S_ENTER;
            end else begin
               w_rank_next  = r_rank + 3'd1;
            end
         end
         S_ENTER, S_WRITE, S_EXIT: begin
            if (w_ack) begin
               w_wait_next  = C_WAIT_LOAD;
               w_state_next = (r_state == S_ENTER) ? S_ENTER_WAIT :
                              (r_state == S_WRITE) ? S_WRITE_WAIT : S_EXIT_WAIT;
            end else if (w_timeout) begin
               w_state_next = S_ERROR;
            end
         end
         S_ENTER_WAIT, S_WRITE_WAIT, S_EXIT_WAIT: begin
            if (r_wait == '0) begin
               if (r_state == S_ENTER_WAIT) begin
                  w_state_next = S_WRITE;
               end else if (r_state == S_WRITE_WAIT) begin
                  w_state_next = S_EXIT;
               end else begin
                  w_state_next = S_RANK_SEL;
                  w_rank_next  = r_rank + 3'd1;
               end
            end else begin
               w_wait_next = r_wait - WW'(1);
            end
         end
         S_DONE, S_ERROR: begin
            if (rerun_vref) begin
               w_state_next = S_RANK_SEL;
               w_rank_next  = 3'd0;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // timeout counts cycles spent in one request state; any transition restarts it
      if (w_state_next != r_state) begin
         w_to_next = '0;
      end else if (w_is_req) begin
         w_to_next = r_to + TW'(1);
      end else begin
         w_to_next = '0;
      end

      w_req_next        = w_is_req & ~w_ack & ~w_timeout;
      w_vref_enable_bit = (r_state != S_EXIT);
      w_sel_next        = (w_state_next != S_IDLE) && (w_state_next != S_DONE) &&
                          (w_state_next != S_ERROR);
   end

   // State and counter registers
   always_ff @(posedge SCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_rank  <= '0;
         r_val_q <= '0;
         r_wait  <= '0;
         r_to    <= '0;
      end else begin
         r_state <= w_state_next;
         r_rank  <= w_rank_next;
         r_val_q <= w_val_next;
         r_wait  <= w_wait_next;
         r_to    <= w_to_next;
      end
   end

   // Registered MR request outputs; they trail request-state entry by one cycle
   always_ff @(posedge SCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_mask     <= '0;
         r_cs       <= '0;
         r_select   <= 1'b0;
         r_complete <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_req      <= w_req_next;
         r_addr     <= w_req_next ? C_MR6_ADDR : 8'h00;
         r_data     <= w_req_next ? {10'b0, w_vref_enable_bit, r_val_q} : 18'h0;
         r_mask     <= w_req_next ? C_MR6_MASK : 18'h0;
         r_cs       <= w_req_next ? w_cs_onehot : '0;
         r_select   <= w_sel_next;
         // sticky flags follow the terminal states and clear when a rerun leaves them
         r_complete <= (w_state_next == S_DONE);
         r_error    <= (w_state_next == S_ERROR);
      end
   end

   assign cal_init_mr_w_req   = r_req;
   assign cal_init_mr_addr    = r_addr;
   assign cal_init_mr_wr_data = r_data;
   assign cal_init_mr_wr_mask = r_mask;
   assign cal_init_cs         = r_cs;
   assign select              = r_select;
   assign ddr4_vref_complete  = r_complete;
   assign vref_error          = r_error;

endmodule

// File: tb/tb_ddr4_vref_mr_seq.sv
// tb/tb_ddr4_vref_mr_seq.sv - directed self-checking bench for ddr4_vref_mr_seq
module tb_ddr4_vref_mr_seq;

   localparam int NR = 2;
   localparam int TV = 8;
   localparam int AT = 16;

   logic              SCLK = 1'b0;
   logic              reset_n = 1'b0;
   logic              training_complete = 1'b0;
   logic              skip_vref_training = 1'b0;
   logic              rerun_vref = 1'b0;
   logic [NR-1:0]     rank_enable = '0;
   logic [7*NR-1:0]   vref_mr6_values = '0;
   logic              cal_init_ack;
   logic              cal_init_mr_w_req;
   logic [7:0]        cal_init_mr_addr;
   logic [17:0]       cal_init_mr_wr_data;
   logic [17:0]       cal_init_mr_wr_mask;
   logic [NR-1:0]     cal_init_cs;
   logic              select;
   logic              ddr4_vref_complete;
   logic              vref_error;

   logic              resp_ack = 1'b0;
   logic              spur_en = 1'b0;

   // spurious acks are only ever offered while the request is low
   assign cal_init_ack = resp_ack | (spur_en & ~cal_init_mr_w_req);

   ddr4_vref_mr_seq #(.NUM_RANKS(NR), .TVREF_WAIT(TV), .ACK_TIMEOUT(AT)) u_dut (
      .SCLK                (SCLK),
      .reset_n             (reset_n),
      .training_complete   (training_complete),
      .skip_vref_training  (skip_vref_training),
      .rerun_vref          (rerun_vref),
      .rank_enable         (rank_enable),
      .vref_mr6_values     (vref_mr6_values),
      .cal_init_ack        (cal_init_ack),
      .cal_init_mr_w_req   (cal_init_mr_w_req),
      .cal_init_mr_addr    (cal_init_mr_addr),
      .cal_init_mr_wr_data (cal_init_mr_wr_data),
      .cal_init_mr_wr_mask (cal_init_mr_wr_mask),
      .cal_init_cs         (cal_init_cs),
      .select              (select),
      .ddr4_vref_complete  (ddr4_vref_complete),
      .vref_error          (vref_error)
   );

   always #5 SCLK = ~SCLK;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int n_sel_cyc = 0;
   int n_req = 0;
   int n_acked = 0;
   int ack_limit = 1000000;
   int hi_cnt = 0;
   bit prev_req = 1'b0;
   logic [17:0]   wr_data[$];
   logic [17:0]   wr_mask[$];
   logic [7:0]    wr_addr[$];
   logic [NR-1:0] wr_cs[$];
   int            rise_cyc[$];
   int            fall_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Arbiter model: acks each request on its third high cycle and logs the accepted write
   always @(negedge SCLK) begin
      cyc++;
      if (select) n_sel_cyc++;
      if (cal_init_mr_w_req && !prev_req) begin
         n_req++;
         rise_cyc.push_back(cyc);
      end
      if (!cal_init_mr_w_req && prev_req) fall_cyc.push_back(cyc);
      prev_req = cal_init_mr_w_req;
      if (!reset_n) begin
         resp_ack = 1'b0;
         hi_cnt   = 0;
      end else if (resp_ack) begin
         resp_ack = 1'b0;
         hi_cnt   = 0;
      end else if (cal_init_mr_w_req) begin
         hi_cnt++;
         if (hi_cnt == 3 && n_acked < ack_limit) begin
            resp_ack = 1'b1;
            n_acked++;
            wr_data.push_back(cal_init_mr_wr_data);
            wr_mask.push_back(cal_init_mr_wr_mask);
            wr_addr.push_back(cal_init_mr_addr);
            wr_cs.push_back(cal_init_cs);
         end
      end else begin
         hi_cnt = 0;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge SCLK);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!ddr4_vref_complete && k < 2000) begin
         @(negedge SCLK);
         k++;
      end
      check(tag, 32'(ddr4_vref_complete), 32'd1);
   endtask

   task automatic wait_acked(input int target, input string tag);
      int k = 0;
      while (n_acked < target && k < 500) begin
         @(negedge SCLK);
         k++;
      end
      check(tag, 32'(n_acked >= target), 32'd1);
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      int k = 0;
      while (cal_init_mr_w_req !== lvl && k < 500) begin
         @(negedge SCLK);
         k++;
      end
      check(tag, 32'(cal_init_mr_w_req), 32'(lvl));
   endtask

   task automatic pulse_rerun();
      rerun_vref = 1'b1;
      @(negedge SCLK);
      rerun_vref = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      training_complete = 1'b0;
      skip_vref_training = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(1);
   endtask

   // Three MR6 writes of one rank: enter, write, exit
   task automatic check_rank(input string tag, input int idx, input logic [NR-1:0] cs,
                             input logic [17:0] d_on, input logic [17:0] d_off);
      if (wr_data.size() < idx + 3) begin
         check({tag, "_present"}, 32'(wr_data.size()), 32'(idx + 3));
      end else begin
         for (int i = 0; i < 3; i++) begin
            check({tag, "_cs"},   32'(wr_cs[idx+i]),   32'(cs));
            check({tag, "_addr"}, 32'(wr_addr[idx+i]), 32'h06);
            check({tag, "_mask"}, 32'(wr_mask[idx+i]), 32'h3FF00);
            check({tag, "_data"}, 32'(wr_data[idx+i]), 32'((i == 2) ? d_off : d_on));
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req"},  32'(cal_init_mr_w_req),   32'd0);
      check({tag, "_addr"}, 32'(cal_init_mr_addr),    32'd0);
      check({tag, "_data"}, 32'(cal_init_mr_wr_data), 32'd0);
      check({tag, "_mask"}, 32'(cal_init_mr_wr_mask), 32'd0);
      check({tag, "_cs"},   32'(cal_init_cs),         32'd0);
      check({tag, "_sel"},  32'(select),              32'd0);
      check({tag, "_done"}, 32'(ddr4_vref_complete),  32'd0);
      check({tag, "_err"},  32'(vref_error),          32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rb, wb, ab, sb, k, min_gap;

      // reset state
      wait_cycles(3);
      check_outputs_zero("rst");
      reset_n = 1'b1;
      wait_cycles(3);
      check("idle_sel", 32'(select), 32'd0);

      // two ranks, both enabled
      rank_enable = 2'b11;
      vref_mr6_values = {7'h25, 7'h4A};
      rb = n_req;
      wb = wr_data.size();
      training_complete = 1'b1;
      wait_done("main_done");
      check("main_nreq", 32'(n_req - rb), 32'd6);
      check_rank("main_r0", wb, 2'b01, 18'h0CA, 18'h04A);
      check_rank("main_r1", wb + 3, 2'b10, 18'h0A5, 18'h025);
      min_gap = 1000;
      for (int i = rb + 1; i < rb + 6 && i < rise_cyc.size(); i++) begin
         if (rise_cyc[i] - fall_cyc[i-1] < min_gap) min_gap = rise_cyc[i] - fall_cyc[i-1];
      end
      check("main_gap_ok", 32'(min_gap >= TV), 32'd1);
      check("main_err", 32'(vref_error), 32'd0);
      check("main_sel", 32'(select), 32'd0);
      check("main_cs", 32'(cal_init_cs), 32'd0);

      // rerun with no enabled ranks
      rank_enable = 2'b00;
      rb = n_req;
      pulse_rerun();
      check("rr0_clr", 32'(ddr4_vref_complete), 32'd0);
      check("rr0_sel", 32'(select), 32'd1);
      wait_done("rr0_done");
      check("rr0_nreq", 32'(n_req - rb), 32'd0);

      // skip straight to done
      reset_n = 1'b0;
      training_complete = 1'b0;
      wait_cycles(2);
      check("skip_rst_done", 32'(ddr4_vref_complete), 32'd0);
      reset_n = 1'b1;
      wait_cycles(1);
      rank_enable = 2'b11;
      skip_vref_training = 1'b1;
      sb = n_sel_cyc;
      rb = n_req;
      training_complete = 1'b1;
      wait_cycles(2);
      check("skip_done", 32'(ddr4_vref_complete), 32'd1);
      wait_cycles(5);
      check("skip_nreq", 32'(n_req - rb), 32'd0);
      check("skip_nsel", 32'(n_sel_cyc - sb), 32'd0);

      // rank 1 only, spurious acks while req low, VREF input changed mid-rank
      do_reset();
      rank_enable = 2'b10;
      vref_mr6_values = {7'h33, 7'h11};
      spur_en = 1'b1;
      rb = n_req;
      wb = wr_data.size();
      ab = n_acked;
      training_complete = 1'b1;
      wait_acked(ab + 1, "r1_first_ack");
      vref_mr6_values = {7'h05, 7'h11};
      wait_done("r1_done");
      spur_en = 1'b0;
      check("r1_nreq", 32'(n_req - rb), 32'd3);
      check_rank("r1", wb, 2'b10, 18'h0B3, 18'h033);

      // ack withheld on WRITE -> timeout error, then rerun recovers
      do_reset();
      rank_enable = 2'b01;
      vref_mr6_values = {7'h00, 7'h5C};
      ab = n_acked;
      ack_limit = ab + 1;
      training_complete = 1'b1;
      wait_acked(ab + 1, "to_enter_ack");
      wait_req(1'b0, "to_req_drop");
      wait_req(1'b1, "to_write_req");
      k = 0;
      while (!vref_error && k < 100) begin
         @(negedge SCLK);
         k++;
      end
      check("to_cycles", 32'(k), 32'(AT - 1));
      check("to_err", 32'(vref_error), 32'd1);
      check("to_req", 32'(cal_init_mr_w_req), 32'd0);
      check("to_done", 32'(ddr4_vref_complete), 32'd0);
      check("to_sel", 32'(select), 32'd0);
      ack_limit = 1000000;
      wb = wr_data.size();
      pulse_rerun();
      check("to_rr_clr", 32'(vref_error), 32'd0);
      wait_done("to_rr_done");
      check("to_rr_err", 32'(vref_error), 32'd0);
      check_rank("to_rr", wb, 2'b01, 18'h0DC, 18'h05C);

      // asynchronous reset during WRITE_WAIT, then a fresh start from rank 0
      rank_enable = 2'b11;
      vref_mr6_values = {7'h25, 7'h4A};
      ab = n_acked;
      pulse_rerun();
      wait_acked(ab + 2, "ar_write_ack");
      wait_cycles(3);
      check("ar_sel_pre", 32'(select), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("ar");
      rb = n_req;
      training_complete = 1'b0;
      wait_cycles(4);
      reset_n = 1'b1;
      wait_cycles(5);
      check("ar_idle_sel", 32'(select), 32'd0);
      check("ar_nreq", 32'(n_req - rb), 32'd0);
      wb = wr_data.size();
      training_complete = 1'b1;
      wait_done("ar_done");
      check("ar_nreq2", 32'(n_req - rb), 32'd6);
      check_rank("ar_r0", wb, 2'b01, 18'h0CA, 18'h04A);
      check_rank("ar_r1", wb + 3, 2'b10, 18'h0A5, 18'h025);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
